// File: rtl/marquee_pkg.sv
// Shared definitions for the marquee scroller: mode codes, FSM states
// and the hex-to-7-segment pattern table (active-low, bit 0 = segment A).
package marquee_pkg;

  localparam logic [1:0] MODE_ROTATE  = 2'd0;
  localparam logic [1:0] MODE_BOUNCE  = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry i is the pattern for hex digit i; the first element listed is F.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    return SEG_TABLE[hex];
  endfunction

endpackage

// File: rtl/marquee_tick_gen.sv
// Clock-enable divider: emits a one-cycle tick every DIV enabled cycles.
// The count only advances while en is high; clr restarts the period.
module marquee_tick_gen #(
  parameter int DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Period counter; clr takes priority so a restart always begins a full period.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/marquee_scan.sv
// Scrolling multi-digit common-anode 7-segment driver.
// Holds SEQ_LEN hex symbols and scrolls a DIGITS-wide window across them
// (rotate, bounce or one-shot), time-multiplexing the window onto the digits.
// Optional feature: define MARQUEE_DP_MARK_EN to light the decimal point on
// the digit currently showing symbol 0; otherwise dp is held high.
module marquee_scan #(
  parameter int DIGITS     = 8,
  parameter int SEQ_LEN    = 16,
  parameter int SCROLL_DIV = 50_000_000,
  parameter int SCAN_DIV   = 5_000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       load,
  input  logic [4*SEQ_LEN-1:0]       seq,
  input  logic [1:0]                 mode,
  input  logic                       dir,
  input  logic                       enable,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [DIGITS-1:0]          an,
  output logic [$clog2(SEQ_LEN)-1:0] pos,
  output logic                       busy,
  output logic                       done
);

  import marquee_pkg::*;

  localparam int PW  = $clog2(SEQ_LEN);
  localparam int DW  = $clog2(DIGITS);
  localparam int LIM = SEQ_LEN - DIGITS;
  localparam logic [PW-1:0] LIM_P  = PW'(LIM);
  localparam logic [PW-1:0] LAST_P = PW'(SEQ_LEN - 1);
  localparam logic [PW:0]   SEQ_W  = (PW+1)'(SEQ_LEN);
  localparam logic [DW-1:0] LAST_D = DW'(DIGITS - 1);

  state_t                 state_q, state_d;
  logic [PW-1:0]          pos_q, pos_d, pos_inc, pos_dec;
  logic                   up_q, up_d;
  logic                   done_q, done_d;
  logic                   busy_q;
  logic [1:0]             mode_q;
  logic [4*SEQ_LEN-1:0]   seq_buf;
  logic [DW-1:0]          scan_idx;
  logic                   step_tick, scan_tick;
  logic [PW:0]            sym_sum;
  logic [PW-1:0]          sym_idx;
  logic [3:0]             sym;
  logic [DIGITS-1:0]      an_d;
  logic [6:0]             seg_q;
  logic [DIGITS-1:0]      an_q;

  marquee_tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (enable),
    .clr     (load),
    .tick    (step_tick)
  );

  marquee_tick_gen #(.DIV(SCAN_DIV)) u_scan_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (1'b1),
    .clr     (1'b0),
    .tick    (scan_tick)
  );

  assign pos_inc = pos_q + PW'(1);
  assign pos_dec = pos_q - PW'(1);

  // Next-state logic: load restarts everything and swallows a coincident step.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    up_d    = up_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = ST_RUN;
      pos_d   = '0;
      up_d    = 1'b1;
    end else if (state_q == ST_RUN && step_tick) begin
      case (mode_q)
        MODE_BOUNCE: begin
          if (LIM == 0) begin
            pos_d = '0;
          end else if (up_q) begin
            if (pos_q >= LIM_P) begin
              pos_d = pos_dec;
              up_d  = 1'b0;
            end else begin
              pos_d = pos_inc;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = pos_inc;
              up_d  = 1'b1;
            end else begin
              pos_d = pos_dec;
            end
          end
        end
        MODE_ONESHOT: begin
          if (LIM == 0) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            pos_d = pos_inc;
            if (pos_inc == LIM_P) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          if (dir)
            pos_d = (pos_q == LAST_P) ? '0 : pos_inc;
          else
            pos_d = (pos_q == '0) ? LAST_P : pos_dec;
        end
      endcase
    end
  end

  // Scroll state registers, plus sequence/mode capture on load.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      up_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      mode_q  <= MODE_ROTATE;
      seq_buf <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      up_q    <= up_d;
      done_q  <= done_d;
      busy_q  <= (state_d == ST_RUN);
      if (load) begin
        mode_q  <= mode;
        seq_buf <= seq;
      end
    end
  end

  // Digit scan index walks through the digits forever, independent of state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      scan_idx <= '0;
    else if (scan_tick)
      scan_idx <= (scan_idx == LAST_D) ? '0 : scan_idx + DW'(1);
  end

  // Symbol under the scanned digit: (pos + k) mod SEQ_LEN, and its anode mask.
  always_comb begin
    sym_sum = {1'b0, pos_q} + (PW+1)'(scan_idx);
    sym_idx = (sym_sum >= SEQ_W) ? PW'(sym_sum - SEQ_W) : PW'(sym_sum);
    sym     = seq_buf[{sym_idx, 2'b00} +: 4];
    an_d    = '1;
    for (int k = 0; k < DIGITS; k++)
      an_d[k] = (scan_idx != DW'(k));
  end

  // Segment and anode drive registered together so they stay aligned.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else if (state_q == ST_IDLE) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= hex_to_seg(sym);
      an_q  <= an_d;
    end
  end

`ifdef MARQUEE_DP_MARK_EN
  logic dp_q;

  // Start-of-sequence marker: decimal point on the digit showing symbol 0.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      dp_q <= 1'b1;
    else if (state_q == ST_IDLE)
      dp_q <= 1'b1;
    else
      dp_q <= (sym_idx != '0);
  end

  assign dp = dp_q;
`else
  assign dp = 1'b1;
`endif

  assign seg  = seg_q;
  assign an   = an_q;
  assign pos  = pos_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
